i2c_bus_monitor: RTL
====================

# i2c_bus_monitor

Upstream front-end for the I2C address-translation path. Oversamples the raw SCL/SDA pins with a free-running system clock, synchronizes and deglitches them, and detects START, repeated START and STOP conditions. Deserializes each 8-bit byte and its ACK bit, and tags the first byte of every frame as the address byte. The translator and logging stages consume these clean, single-cycle events instead of clocking directly off the bus.

## Interface
Parameters:
- FILT_LEN, 3: consecutive identical synchronized samples required before a filtered level changes (legal range 1–15).

Ports:
- clk  in  1  system clock; must be ≥ 8× SCL frequency.
- rst_n  in  1  reset, asynchronous, active-low.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- start_det  out  1  one-cycle pulse on START from bus-free.
- rstart_det  out  1  one-cycle pulse on repeated START while busy.
- stop_det  out  1  one-cycle pulse on STOP.
- byte_out  out  8  last completed byte, MSB first on the bus; held until the next byte completes.
- byte_valid  out  1  one-cycle pulse when byte_out updates.
- is_addr  out  1  qualifies byte_valid: 1 = first byte after START/rSTART; held with byte_out.
- ack_out  out  1  sampled 9th-bit level (0 = ACK); held.
- ack_valid  out  1  one-cycle pulse when ack_out updates.
- bus_busy  out  1  level; 1 from START until STOP.
- err  out  1  one-cycle pulse on START/STOP inside a byte.

## Operation
- Input path: two-flop synchronizer per pin, reset to 1.
- Deglitch filter per pin: 4-bit counter.
  - Counter clears whenever the synchronized sample equals the filtered level.
  - Filtered level flips after FILT_LEN consecutive differing samples.
  - Filtered levels reset to 1.
- Edge detect: compare each filtered signal with its previous-cycle copy.
  - scl_rise, scl_fall internal.
  - sda_fall_c and sda_rise_c qualify only when filtered SCL is 1 in both the current and previous cycle.
- Conditions:
  - START = sda_fall_c.
  - STOP = sda_rise_c.
  - An SDA edge in the same cycle as an SCL edge is not a condition.
- FSM states IDLE, BITS, ACK. Internal state: bit_cnt (0–8), shift reg, first_byte flag.
  - IDLE: ignore SCL edges. START → start_det, bus_busy=1, first_byte=1, bit_cnt=0, go to BITS.
  - BITS: on scl_rise, shift in filtered SDA and increment bit_cnt. When bit_cnt reaches 8:
    - byte_out = shift reg.
    - is_addr = first_byte.
    - byte_valid pulse.
    - first_byte = 0.
    - go to ACK.
  - ACK: on scl_rise, ack_out = SDA, ack_valid pulse, bit_cnt=0, go to BITS.
- START while bus_busy (any state):
  - rstart_det pulse (not start_det), first_byte=1, bit_cnt=0, go to BITS.
  - If in BITS with bit_cnt 1–7, or in ACK, also pulse err; the partial byte is discarded.
- STOP (any non-IDLE state):
  - stop_det pulse, bus_busy=0, go to IDLE.
  - If in BITS with bit_cnt 1–7, or in ACK, also pulse err; the partial byte is discarded.
- STOP while in IDLE: stop_det pulses; no other effect.
- Conditions take priority over bit sampling. They cannot coincide with scl_rise, because conditions require SCL to be stable.

## Timing
- Pin-to-filtered latency: 2 + FILT_LEN clk cycles.
- Event outputs are registered; each pulse is asserted for the single cycle after the detecting edge.
- byte_valid: one cycle after the filtered 8th SCL rise.
- ack_valid: one cycle after the filtered 9th SCL rise.
- byte_out, is_addr and ack_out change only in the cycle their valid pulse is high.
- Reset values:
  - All pulses 0; bus_busy 0.
  - byte_out 8'h00, is_addr 0, ack_out 1.
  - State IDLE, bit_cnt 0.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, the block ignores the bus until the next START, including the remainder of the interrupted frame and any STOP-less data.
- Pin glitches of width < FILT_LEN cycles produce no filtered edge and no events.

## Test plan
- START, 0x42, ACK=0, 0xA5, ACK=1, STOP → start_det; byte 0x42 with is_addr=1 and ack 0; byte 0xA5 with is_addr=0 and ack 1; stop_det; bus_busy high exactly between start_det and stop_det.
- START, 0x44, ACK, rSTART, 0x45, ACK, STOP → rstart_det (no start_det); 0x45 flagged is_addr=1; no err.
- START, 0x42, then STOP after 4 data bits → err and stop_det in the same cycle; no second byte_valid; IDLE.
- SDA low glitch of FILT_LEN−1 cycles while SCL high and bus idle → no start_det; bus_busy stays 0.
- SCL pulses and SDA toggles while idle, no START → no byte_valid or ack_valid.
- rst_n low after 5 bits of a frame, released, 3 more bits sent, then a full START/0x42/STOP frame → only the second frame's events appear; outputs show reset values during reset.

Source files
------------

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: oversampled I2C front-end. Synchronizes and deglitches SCL/SDA,
// detects START/rSTART/STOP and deserializes each byte plus its ACK bit.
module i2c_bus_monitor #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       start_det,
    output logic       rstart_det,
    output logic       stop_det,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       is_addr,
    output logic       ack_out,
    output logic       ack_valid,
    output logic       bus_busy,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, BITS, ACK} state_t;

    localparam logic [3:0] FiltLast = 4'(FILT_LEN - 1);

    logic [1:0] sclSync_q, sdaSync_q;
    logic [3:0] sclCnt_q, sdaCnt_q;
    logic       sclFilt_q, sdaFilt_q, sclPrev_q, sdaPrev_q;

    // A filtered level only follows the pin after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclSync_q <= 2'b11;
            sdaSync_q <= 2'b11;
            sclCnt_q  <= '0;
            sdaCnt_q  <= '0;
            sclFilt_q <= 1'b1;
            sdaFilt_q <= 1'b1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[0], scl_in};
            sdaSync_q <= {sdaSync_q[0], sda_in};
            sclPrev_q <= sclFilt_q;
            sdaPrev_q <= sdaFilt_q;
            if (sclSync_q[1] == sclFilt_q) begin
                sclCnt_q <= '0;
            end else if (sclCnt_q == FiltLast) begin
                sclFilt_q <= sclSync_q[1];
                sclCnt_q  <= '0;
            end else begin
                sclCnt_q <= sclCnt_q + 4'd1;
            end
            if (sdaSync_q[1] == sdaFilt_q) begin
                sdaCnt_q <= '0;
            end else if (sdaCnt_q == FiltLast) begin
                sdaFilt_q <= sdaSync_q[1];
                sdaCnt_q  <= '0;
            end else begin
                sdaCnt_q <= sdaCnt_q + 4'd1;
            end
        end
    end

    state_t     state_q;
    logic [3:0] bitCnt_q;
    logic [6:0] shift_q;
    logic       firstByte_q, busy_q;
    logic       startDet_q, rstartDet_q, stopDet_q, err_q;
    logic [7:0] byteOut_q;
    logic       byteValid_q, isAddr_q, ackOut_q, ackValid_q;

    logic sclRise, sclStable, startCond, stopCond, midByte;

    // SDA edges count as conditions only while SCL has been high for two cycles.
    assign sclRise   = sclFilt_q & ~sclPrev_q;
    assign sclStable = sclFilt_q & sclPrev_q;
    assign startCond = sclStable & sdaPrev_q & ~sdaFilt_q;
    assign stopCond  = sclStable & ~sdaPrev_q & sdaFilt_q;
    assign midByte   = (state_q == ACK) || ((state_q == BITS) && (bitCnt_q != 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            firstByte_q <= 1'b0;
            busy_q      <= 1'b0;
            startDet_q  <= 1'b0;
            rstartDet_q <= 1'b0;
            stopDet_q   <= 1'b0;
            err_q       <= 1'b0;
            byteOut_q   <= 8'h00;
            byteValid_q <= 1'b0;
            isAddr_q    <= 1'b0;
            ackOut_q    <= 1'b1;
            ackValid_q  <= 1'b0;
        end else begin
            startDet_q  <= 1'b0;
            rstartDet_q <= 1'b0;
            stopDet_q   <= 1'b0;
            err_q       <= 1'b0;
            byteValid_q <= 1'b0;
            ackValid_q  <= 1'b0;
            if (startCond) begin
                if (state_q == IDLE) begin
                    startDet_q <= 1'b1;
                end else begin
                    rstartDet_q <= 1'b1;
                    err_q       <= midByte;
                end
                busy_q      <= 1'b1;
                firstByte_q <= 1'b1;
                bitCnt_q    <= '0;
                state_q     <= BITS;
            end else if (stopCond) begin
                stopDet_q <= 1'b1;
                if (state_q != IDLE) begin
                    err_q    <= midByte;
                    busy_q   <= 1'b0;
                    bitCnt_q <= '0;
                    state_q  <= IDLE;
                end
            end else begin
                case (state_q)
                    BITS: begin
                        if (sclRise) begin
                            shift_q <= {shift_q[5:0], sdaFilt_q};
                            if (bitCnt_q == 4'd7) begin
                                byteOut_q   <= {shift_q, sdaFilt_q};
                                isAddr_q    <= firstByte_q;
                                byteValid_q <= 1'b1;
                                firstByte_q <= 1'b0;
                                bitCnt_q    <= 4'd8;
                                state_q     <= ACK;
                            end else begin
                                bitCnt_q <= bitCnt_q + 4'd1;
                            end
                        end
                    end
                    ACK: begin
                        if (sclRise) begin
                            ackOut_q   <= sdaFilt_q;
                            ackValid_q <= 1'b1;
                            bitCnt_q   <= '0;
                            state_q    <= BITS;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign start_det  = startDet_q;
    assign rstart_det = rstartDet_q;
    assign stop_det   = stopDet_q;
    assign err        = err_q;
    assign byte_out   = byteOut_q;
    assign byte_valid = byteValid_q;
    assign is_addr    = isAddr_q;
    assign ack_out    = ackOut_q;
    assign ack_valid  = ackValid_q;
    assign bus_busy   = busy_q;
endmodule
